// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage; drives a req/ack data port and returns extended loads.
// Optional LSU_TIMEOUT_EN: fault a memory access that sees no mem_ack within TIMEOUT_CYCLES.
module load_store_unit #(
    parameter int          ADDR_W         = 32,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);
    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d, fault_q, fault_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          lo_q, lo_d;
`ifdef LSU_TIMEOUT_EN
    logic [7:0]          cnt_q, cnt_d;
`else
    logic                unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // funct3[1:0] encodes access size (00 byte, 01 half, 10 word); bit 2 marks unsigned loads
    logic        illegal, misaligned;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_val;
    assign illegal    = req_is_store ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                                     : (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110);
    assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign lane_b     = mem_rdata[{lo_q, 3'b000} +: 8];
    assign lane_h     = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ld_val     = f3_q[1] ? mem_rdata :
                        f3_q[0] ? {{16{~f3_q[2] & lane_h[15]}}, lane_h} :
                                  {{24{~f3_q[2] & lane_b[7]}}, lane_b};

    assign req_ready = (state_q == IDLE) && !reset;
    assign mem_req   = (state_q == MEM);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

    // Next-state: latch request in IDLE, wait for ack (or timeout) in MEM, hold response in RESP
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                f3_d    = req_funct3;
                lo_d    = req_addr[1:0];
                addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                we_d    = req_is_store;
                wstrb_d = !req_is_store           ? 4'b0000 :
                          req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
                          req_funct3[1:0] == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
                wdata_d = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                          req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
                rdata_d = 32'd0;
                fault_d = illegal || misaligned;
                state_d = (illegal || misaligned) ? RESP : MEM;
`ifdef LSU_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end
            MEM: if (mem_ack) begin
                rdata_d = we_q ? 32'd0 : ld_val;
                fault_d = 1'b0;
                state_d = RESP;
            end
`ifdef LSU_TIMEOUT_EN
            else begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_d == TIMEOUT_CYCLES) begin
                    rdata_d = 32'd0;
                    fault_d = 1'b1;
                    state_d = RESP;
                end
            end
`endif
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access or pending response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            f3_q    <= 3'd0;
            lo_q    <= 2'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit handshakes, lane mapping and faults.
module tb_load_store_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'd0;
    logic [3:0]  mem_wstrb;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_fault;
    logic [31:0] rsp_rdata;
    int          total = 0, passed = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one cycle; returns just after the accepting edge
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rd);
        mem_ack = 1'b1; mem_rdata = rd;
        step();
        mem_ack = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        step(); step();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // LB 0x1003, ack at N+1
        issue(1'b0, 3'b000, 32'h1003, 32'd0);
        chk("lb_mem_req", {31'd0, mem_req}, 32'd1);
        chk("lb_mem_addr", mem_addr, 32'h1000);
        chk("lb_mem_we", {31'd0, mem_we}, 32'd0);
        chk("lb_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("lb_req_ready", {31'd0, req_ready}, 32'd0);
        chk("lb_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        ack(32'h80FF1234);
        chk("lb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("lb_mem_req_drop", {31'd0, mem_req}, 32'd0);
        chk("lb_rdata", rsp_rdata, 32'hFFFFFF80);
        chk("lb_fault", {31'd0, rsp_fault}, 32'd0);
        consume();
        chk("lb_done_valid", {31'd0, rsp_valid}, 32'd0);
        chk("lb_done_ready", {31'd0, req_ready}, 32'd1);

        // LHU / LH 0x2002
        issue(1'b0, 3'b101, 32'h2002, 32'd0);
        chk("lhu_mem_addr", mem_addr, 32'h2000);
        ack(32'hBEEF0000);
        chk("lhu_rdata", rsp_rdata, 32'h0000BEEF);
        consume();
        issue(1'b0, 3'b001, 32'h2002, 32'd0);
        chk("lh_mem_addr", mem_addr, 32'h2000);
        ack(32'hBEEF0000);
        chk("lh_rdata", rsp_rdata, 32'hFFFFBEEF);
        consume();

        // LBU byte 1 and LB positive byte 0
        issue(1'b0, 3'b100, 32'h2101, 32'd0);
        ack(32'h1122F344);
        chk("lbu_rdata", rsp_rdata, 32'h000000F3);
        consume();
        issue(1'b0, 3'b000, 32'h2100, 32'd0);
        ack(32'h1122F344);
        chk("lb_pos_rdata", rsp_rdata, 32'h00000044);
        consume();

        // SB 0x3001
        issue(1'b1, 3'b000, 32'h3001, 32'h000000AA);
        chk("sb_mem_req", {31'd0, mem_req}, 32'd1);
        chk("sb_mem_we", {31'd0, mem_we}, 32'd1);
        chk("sb_wstrb", {28'd0, mem_wstrb}, 32'b0010);
        chk("sb_wdata", mem_wdata, 32'hAAAAAAAA);
        chk("sb_mem_addr", mem_addr, 32'h3000);
        ack(32'h12345678);
        chk("sb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("sb_rdata", rsp_rdata, 32'd0);
        chk("sb_fault", {31'd0, rsp_fault}, 32'd0);
        consume();

        // SH 0x3002 and SW 0x3004
        issue(1'b1, 3'b001, 32'h3002, 32'h1234BEEF);
        chk("sh_wstrb", {28'd0, mem_wstrb}, 32'b1100);
        chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
        ack(32'd0);
        consume();
        issue(1'b1, 3'b010, 32'h3004, 32'hCAFEF00D);
        chk("sw_wstrb", {28'd0, mem_wstrb}, 32'b1111);
        chk("sw_wdata", mem_wdata, 32'hCAFEF00D);
        chk("sw_mem_addr", mem_addr, 32'h3004);
        ack(32'hFFFFFFFF);
        chk("sw_rdata", rsp_rdata, 32'd0);
        consume();

        // Faults: misaligned LW, illegal load funct3, illegal store funct3, misaligned LH
        issue(1'b0, 3'b010, 32'h4002, 32'd0);
        chk("lw_mis_mem_req", {31'd0, mem_req}, 32'd0);
        chk("lw_mis_valid", {31'd0, rsp_valid}, 32'd1);
        chk("lw_mis_fault", {31'd0, rsp_fault}, 32'd1);
        chk("lw_mis_rdata", rsp_rdata, 32'd0);
        consume();
        chk("lw_mis_no_mem", {31'd0, mem_req}, 32'd0);
        issue(1'b0, 3'b011, 32'h4000, 32'd0);
        chk("ld011_mem_req", {31'd0, mem_req}, 32'd0);
        chk("ld011_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ld011_fault", {31'd0, rsp_fault}, 32'd1);
        chk("ld011_rdata", rsp_rdata, 32'd0);
        consume();
        issue(1'b1, 3'b100, 32'h4000, 32'd0);
        chk("st100_fault", {31'd0, rsp_fault}, 32'd1);
        chk("st100_mem_req", {31'd0, mem_req}, 32'd0);
        consume();
        issue(1'b0, 3'b001, 32'h4001, 32'd0);
        chk("lh_mis_fault", {31'd0, rsp_fault}, 32'd1);
        consume();

        // Stray ack while idle is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("stray_ack_valid", {31'd0, rsp_valid}, 32'd0);
        chk("stray_ack_ready", {31'd0, req_ready}, 32'd1);

        // Slow memory: two wait cycles before ack
        issue(1'b0, 3'b010, 32'h6000, 32'd0);
        step();
        chk("wait_mem_req", {31'd0, mem_req}, 32'd1);
        chk("wait_mem_addr", mem_addr, 32'h6000);
        step();
        chk("wait2_mem_req", {31'd0, mem_req}, 32'd1);
        chk("wait2_no_rsp", {31'd0, rsp_valid}, 32'd0);
        ack(32'h89ABCDEF);
        chk("wait_rdata", rsp_rdata, 32'h89ABCDEF);
        consume();

        // Back-pressure with a competing request held during RESP
        issue(1'b0, 3'b100, 32'h5002, 32'd0);
        ack(32'h00C30000);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h5100;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata", rsp_rdata, 32'h000000C3);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
            step();
        end
        chk("bp_no_mem", {31'd0, mem_req}, 32'd0);
        req_valid = 1'b0;
        consume();
        chk("bp_done", {31'd0, rsp_valid}, 32'd0);
        chk("bp_done_ready", {31'd0, req_ready}, 32'd1);

        // Reset during MEM abandons the access
        issue(1'b0, 3'b010, 32'h7000, 32'd0);
        chk("rstmid_mem_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        step();
        chk("rstmid_mem_drop", {31'd0, mem_req}, 32'd0);
        chk("rstmid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("rstmid_still_idle", {31'd0, rsp_valid}, 32'd0);
        chk("rstmid_still_nomem", {31'd0, mem_req}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between execute and writeback of the RV32I core.
- Accepts one load or store per transaction from execute and drives the data-memory port with a req/ack handshake.
- On loads, selects the addressed byte or halfword lane and sign- or zero-extends it to 32 bits (LB/LH/LBU/LHU), using the same extension rules as the byte extender.
- Returns a completion response to writeback with a valid/ready handshake.

Parameters:
- ADDR_W, 32, width of request and memory address.
- TIMEOUT_CYCLES, 255, cycles to wait for mem_ack before faulting. Used only when LSU_TIMEOUT_EN is defined; must be ≥1 and fit in 8 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  execute presents a request
- req_ready  output  1  unit can accept a request
- req_is_store  input  1  1=store, 0=load
- req_funct3  input  3  RV32I funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW)
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data (low bits used for SB/SH)
- mem_req  output  1  memory access in progress
- mem_we  output  1  write enable
- mem_addr  output  ADDR_W  word address, bits[1:0]=00
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte-lane write strobes
- mem_ack  input  1  memory completes the current access; sampled only while mem_req=1
- mem_rdata  input  32  read word, valid in the mem_ack cycle
- rsp_valid  output  1  response available
- rsp_ready  input  1  writeback consumes the response
- rsp_rdata  output  32  extended load result; 0 for stores and faults
- rsp_fault  output  1  misaligned access, illegal funct3, or timeout

Behaviour:
- Reset values: req_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0. The FSM returns to IDLE and req_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation abandons the transaction: mem_req drops the next cycle, and any pending response is discarded.
- FSM states: IDLE, MEM, RESP.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid & req_ready) registers the request.
  - Legal and aligned request -> MEM.
  - Misaligned or illegal funct3 -> RESP with rsp_fault=1 and no memory access.
- Alignment rules:
  - Halfword needs addr[0]=0.
  - Word needs addr[1:0]=00.
  - Byte is always aligned.
  - Illegal load funct3: 011, 110, 111. Illegal store funct3: anything other than 000/001/010.
- MEM:
  - mem_req=1 and all mem_* outputs are stable until the ack cycle.
  - mem_addr = {addr[ADDR_W-1:2], 2'b00}.
- Store lane mapping:
  - SB: strobe = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: strobe = 0011 << addr[1:0]; wdata = halfword replicated ×2.
  - SW: strobe = 1111; wdata = req_wdata.
- Loads: mem_we=0, mem_wstrb=0000.
- On mem_ack: capture the lane from mem_rdata (byte addr[1:0]; halfword addr[1]) and extend it. Then mem_req=0 and go to RESP on the next cycle.
  - LB/LH replicate the selected lane's MSB.
  - LBU/LHU zero-fill.
  - LW passes the word through.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_fault are held stable until rsp_ready=1.
  - Handshake -> IDLE.
  - No new request is accepted in RESP: req_ready=0 in MEM and RESP.
- Latency: request accepted at cycle N -> mem_req=1 at N+1 -> ack at N+k -> rsp_valid at N+k+1. Minimum 2 cycles (k=1). A faulting request gives rsp_valid at N+1.
- A mem_ack while mem_req=0 is ignored.
- Store responses return rsp_rdata=0 and rsp_fault=0.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to MEM and increments each MEM cycle without mem_ack.
  - At count==TIMEOUT_CYCLES: drop mem_req and go to RESP with rsp_fault=1, rsp_rdata=0.
  - A mem_ack in the same cycle takes priority over the timeout.
- Undefined: no counter, and MEM waits indefinitely for mem_ack.

Test Plan:
- LB addr=0x1003, mem_rdata=0x80FF1234, ack at N+1 -> rsp_valid at N+2, rsp_rdata=0xFFFFFF80, rsp_fault=0.
- LHU addr=0x2002, mem_rdata=0xBEEF0000 -> rsp_rdata=0x0000BEEF. LH at the same address -> 0xFFFFBEEF. mem_addr=0x2000 in both cases.
- SB addr=0x3001, wdata=0x000000AA -> mem_we=1, mem_wstrb=0010, mem_wdata=0xAAAAAAAA, mem_addr=0x3000. Response has rsp_rdata=0, rsp_fault=0.
- LW addr=0x4002 -> mem_req never asserts, rsp_valid at N+1 with rsp_fault=1. funct3=011 load -> same response.
- Back-pressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0. A reset asserted during MEM -> mem_req=0 and rsp_valid=0 next cycle, then req_ready=1 after reset releases.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> mem_req drops after 4 MEM cycles, rsp_fault=1. Ack on the 4th cycle -> normal response with rsp_fault=0.
